// File: rtl/fft_stream_harness_if.sv
// Host/FFT-side bundle of the stream harness: stimulus load, run control,
// FFT input/output streams, capture readback and status.
interface fft_stream_harness_if #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
);
  logic             ld_en;
  logic [LOG2N-1:0] ld_addr;
  logic [WIDTH-1:0] ld_re;
  logic [WIDTH-1:0] ld_im;
  logic             start;
  logic [7:0]       frames;
  logic [7:0]       gap_len;
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [LOG2N-1:0] rd_addr;
  logic [WIDTH-1:0] rd_re;
  logic [WIDTH-1:0] rd_im;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             overrun;
  logic [LOG2N+7:0] out_cnt;

  modport master (
    output ld_en, ld_addr, ld_re, ld_im, start, frames, gap_len,
           do_en, do_re, do_im, rd_addr,
    input  di_en, di_re, di_im, rd_re, rd_im,
           busy, done, timeout, overrun, out_cnt
  );

  modport slave (
    input  ld_en, ld_addr, ld_re, ld_im, start, frames, gap_len,
           do_en, do_re, do_im, rd_addr,
    output di_en, di_re, di_im, rd_re, rd_im,
           busy, done, timeout, overrun, out_cnt
  );
endinterface

// File: rtl/fft_stream_harness.sv
// Replays a host-loaded N-point frame into an FFT input stream and captures
// the FFT output stream into a readback buffer, with done/timeout/overrun.
module fft_stream_harness #(
  parameter int WIDTH     = 16,
  parameter int LOG2N     = 6,
  parameter int TO_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_stream_harness_if.slave  bus
);
  localparam int N  = 1 << LOG2N;
  localparam int CW = LOG2N + 8;
  localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LOG2N-1:0] ptr_q, ptr_d;
  logic [7:0]       frame_q, frame_d, frames_q, frames_d;
  logic [7:0]       gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d, total;
  logic             di_en_q, di_en_d, busy_q, busy_d, done_q, done_d;
  logic             timeout_q, timeout_d, overrun_q, overrun_d;
  logic [WIDTH-1:0] di_re_q, di_re_d, di_im_q, di_im_d, rd_re_q, rd_im_q;
  logic             stim_we, cap_we, arm;

  logic [WIDTH-1:0] stim_re [N];
  logic [WIDTH-1:0] stim_im [N];
  logic [WIDTH-1:0] cap_re  [N];
  logic [WIDTH-1:0] cap_im  [N];

  assign total = {frames_q, {LOG2N{1'b0}}};
  assign arm   = bus.start && !bus.ld_en && (bus.frames != 8'd0);

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    frame_d   = frame_q;
    frames_d  = frames_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    out_cnt_d = out_cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    stim_we   = 1'b0;
    cap_we    = 1'b0;
    di_en_d   = (state_q == S_PLAY);
    di_re_d   = di_en_d ? stim_re[ptr_q] : di_re_q;
    di_im_d   = di_en_d ? stim_im[ptr_q] : di_im_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        stim_we = bus.ld_en;
        if (state_q == S_DONE && bus.do_en) overrun_d = 1'b1;
        if (arm) begin
          state_d   = S_PLAY;
          ptr_d     = '0;
          frame_d   = 8'd0;
          frames_d  = bus.frames;
          gap_len_d = bus.gap_len;
          to_cnt_d  = '0;
          out_cnt_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
        end
      end
      S_PLAY, S_GAP, S_DRAIN: begin
        if (state_q == S_PLAY) begin
          ptr_d = ptr_q + LOG2N'(1);
          if (ptr_q == LOG2N'(N - 1)) begin
            frame_d = frame_q + 8'd1;
            if (frame_q == frames_q - 8'd1) begin
              state_d = S_DRAIN;
            end else if (gap_len_q != 8'd0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_len_q - 8'd1;
            end
          end
        end else if (state_q == S_GAP) begin
          if (gap_cnt_q == 8'd0) state_d = S_PLAY;
          else                   gap_cnt_d = gap_cnt_q - 8'd1;
        end

        // Any do_en restarts the idle timer, even on the cycle it would expire.
        if (bus.do_en) begin
          to_cnt_d = '0;
          if (out_cnt_q != total) begin
            cap_we    = 1'b1;
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end

        if (state_q == S_DRAIN && out_cnt_d == total) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (!bus.do_en && to_cnt_q == TW'(TO_CYCLES - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      frame_q   <= 8'd0;
      frames_q  <= 8'd0;
      gap_len_q <= 8'd0;
      gap_cnt_q <= 8'd0;
      to_cnt_q  <= '0;
      out_cnt_q <= '0;
      di_en_q   <= 1'b0;
      di_re_q   <= '0;
      di_im_q   <= '0;
      rd_re_q   <= '0;
      rd_im_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      frame_q   <= frame_d;
      frames_q  <= frames_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      out_cnt_q <= out_cnt_d;
      di_en_q   <= di_en_d;
      di_re_q   <= di_re_d;
      di_im_q   <= di_im_d;
      rd_re_q   <= cap_re[bus.rd_addr];
      rd_im_q   <= cap_im[bus.rd_addr];
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the buffers are deliberately left out of reset; their contents survive a reset.
  always_ff @(posedge clock) begin
    if (stim_we) begin
      stim_re[bus.ld_addr] <= bus.ld_re;
      stim_im[bus.ld_addr] <= bus.ld_im;
    end
    if (cap_we) begin
      cap_re[out_cnt_q[LOG2N-1:0]] <= bus.do_re;
      cap_im[out_cnt_q[LOG2N-1:0]] <= bus.do_im;
    end
  end

  assign bus.di_en   = di_en_q;
  assign bus.di_re   = di_re_q;
  assign bus.di_im   = di_im_q;
  assign bus.rd_re   = rd_re_q;
  assign bus.rd_im   = rd_im_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.overrun = overrun_q;
  assign bus.out_cnt = out_cnt_q;
endmodule

// File: tb/tb_fft_stream_harness.sv
// Directed bench for fft_stream_harness: ramp stimulus, 10-cycle loopback FFT
// model, table of run configurations plus hand-written corner sequences.
module tb_fft_stream_harness;
  localparam int W  = 16;
  localparam int LN = 6;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stream_harness_if #(.WIDTH(W), .LOG2N(LN)) bus ();

  fft_stream_harness #(.WIDTH(W), .LOG2N(LN), .TO_CYCLES(4096)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Loopback FFT model: do = di delayed by 10 cycles; manual drive when loop_en is low.
  logic         loop_en;
  logic         man_do_en;
  logic [W-1:0] man_re;
  logic [9:0]   pe = '0;
  logic [W-1:0] pr [10];
  logic [W-1:0] pim [10];

  always @(posedge clk) begin
    pe     <= {pe[8:0], bus.di_en};
    pr[0]  <= bus.di_re;
    pim[0] <= bus.di_im;
    for (int i = 1; i < 10; i++) begin
      pr[i]  <= pr[i-1];
      pim[i] <= pim[i-1];
    end
  end

  assign bus.do_en = loop_en ? pe[9]  : man_do_en;
  assign bus.do_re = loop_en ? pr[9]  : man_re;
  assign bus.do_im = loop_en ? pim[9] : man_re;

  int cyc = 0;
  int last_do_cyc = 0;
  int done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.do_en && bus.busy) last_do_cyc <= cyc;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_run(input logic [7:0] fr, input logic [7:0] gp);
    bus.frames  = fr;
    bus.gap_len = gp;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Called at t+1; walks the whole di stream and counts deviating cycles.
  task automatic watch_play(input int fr, input int gp, output int bad);
    logic [W-1:0] ek_re, ek_im;
    bad = 0;
    if (bus.di_en) bad++;
    for (int f = 0; f < fr; f++) begin
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        ek_re = W'(k);
        ek_im = W'(-k);
        if (!bus.di_en || bus.di_re !== ek_re || bus.di_im !== ek_im) bad++;
      end
      if (f < fr - 1) begin
        for (int g = 0; g < gp; g++) begin
          @(negedge clk);
          if (bus.di_en) bad++;
        end
      end
    end
    @(negedge clk);
    if (bus.di_en) bad++;
  endtask

  task automatic wait_done(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done || bus.timeout) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_cap(input logic [LN-1:0] a, output logic [W-1:0] re, output logic [W-1:0] im);
    bus.rd_addr = a;
    @(negedge clk);
    re = bus.rd_re;
    im = bus.rd_im;
  endtask

  typedef struct {
    logic [7:0] frames;
    logic [7:0] gap;
    int         exp_cnt;
  } run_vec_t;

  typedef struct {
    logic [LN-1:0] addr;
    logic [W-1:0]  exp_re;
    logic [W-1:0]  exp_im;
  } rd_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    run_vec_t runs [3];
    rd_vec_t  rds  [4];
    int bad, ok, full_bad;
    logic [W-1:0] re, im;

    runs[0] = '{frames: 8'd1, gap: 8'd0, exp_cnt: 64};
    runs[1] = '{frames: 8'd2, gap: 8'd1, exp_cnt: 128};
    runs[2] = '{frames: 8'd3, gap: 8'd5, exp_cnt: 192};
    rds[0]  = '{addr: 6'd0,  exp_re: 16'h0000, exp_im: 16'h0000};
    rds[1]  = '{addr: 6'd1,  exp_re: 16'h0001, exp_im: 16'hffff};
    rds[2]  = '{addr: 6'd30, exp_re: 16'h001e, exp_im: 16'hffe2};
    rds[3]  = '{addr: 6'd63, exp_re: 16'h003f, exp_im: 16'hffc1};

    rst = 1'b1;
    loop_en = 1'b1; man_do_en = 1'b0; man_re = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_re = '0; bus.ld_im = '0;
    bus.start = 1'b0; bus.frames = 8'd0; bus.gap_len = 8'd0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    bus.busy,    0);
    check("rst_done",    bus.done,    0);
    check("rst_di_en",   bus.di_en,   0);
    check("rst_out_cnt", bus.out_cnt, 0);
    check("rst_di_re",   bus.di_re,   0);
    check("rst_rd_re",   bus.rd_re,   0);
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      bus.ld_en = 1'b1; bus.ld_addr = LN'(k); bus.ld_re = W'(k); bus.ld_im = W'(-k);
      @(negedge clk);
    end
    bus.ld_en = 1'b0;
    @(negedge clk);

    // Run table: loopback runs with varying frame count and gap.
    for (int r = 0; r < 3; r++) begin
      start_run(runs[r].frames, runs[r].gap);
      check($sformatf("run%0d_busy_t1", r), bus.busy, 1);
      watch_play(runs[r].frames, runs[r].gap, bad);
      check($sformatf("run%0d_di_pattern_bad", r), bad, 0);
      wait_done(2000, ok);
      check($sformatf("run%0d_done_seen", r), ok, 1);
      check($sformatf("run%0d_done", r), bus.done, 1);
      check($sformatf("run%0d_timeout", r), bus.timeout, 0);
      check($sformatf("run%0d_busy_end", r), bus.busy, 0);
      check($sformatf("run%0d_out_cnt", r), bus.out_cnt, runs[r].exp_cnt);
      check($sformatf("run%0d_done_latency", r), done_cyc - last_do_cyc, 1);
      for (int v = 0; v < 4; v++) begin
        read_cap(rds[v].addr, re, im);
        check($sformatf("run%0d_rd_re_%0d", r, rds[v].addr), re, rds[v].exp_re);
        check($sformatf("run%0d_rd_im_%0d", r, rds[v].addr), im, rds[v].exp_im);
      end
    end

    full_bad = 0;
    for (int k = 0; k < N; k++) begin
      read_cap(LN'(k), re, im);
      if (re !== W'(k) || im !== W'(-k)) full_bad++;
    end
    check("readback_scan_bad", full_bad, 0);

    // Overrun: do_en after completion is flagged and not captured.
    loop_en = 1'b0;
    man_re = 16'hdead; man_do_en = 1'b1;
    repeat (3) @(negedge clk);
    man_do_en = 1'b0;
    @(negedge clk);
    check("ovr_overrun", bus.overrun, 1);
    check("ovr_out_cnt", bus.out_cnt, 192);
    check("ovr_done",    bus.done,    1);
    read_cap(6'd5, re, im);
    check("ovr_rd_re5", re, 16'h0005);
    check("ovr_rd_im5", im, 16'hfffb);

    // Timeout: no do_en at all, expiry 4096 cycles after the clear.
    start_run(8'd1, 8'd0);
    check("to_overrun_cleared", bus.overrun, 0);
    check("to_t1_timeout", bus.timeout, 0);
    repeat (4095) @(negedge clk);
    check("to_before_expiry", bus.timeout, 0);
    @(negedge clk);
    check("to_timeout", bus.timeout, 1);
    check("to_done",    bus.done,    0);
    check("to_busy",    bus.busy,    0);
    check("to_out_cnt", bus.out_cnt, 0);
    loop_en = 1'b1;

    // Negative: frames=0 and start with ld_en high are ignored.
    start_run(8'd0, 8'd0);
    check("neg_f0_busy", bus.busy, 0);
    @(negedge clk);
    check("neg_f0_di_en", bus.di_en, 0);
    check("neg_f0_timeout_kept", bus.timeout, 1);
    bus.ld_en = 1'b1; bus.ld_addr = 6'd0; bus.ld_re = 16'h0000; bus.ld_im = 16'h0000;
    start_run(8'd1, 8'd0);
    bus.ld_en = 1'b0;
    check("neg_ld_start_busy", bus.busy, 0);

    // ld_en during PLAY must not touch the stimulus buffer.
    start_run(8'd1, 8'd0);
    check("ldp_busy", bus.busy, 1);
    bus.ld_en = 1'b1; bus.ld_addr = 6'd10; bus.ld_re = 16'h7777; bus.ld_im = 16'h7777;
    @(negedge clk);
    bus.ld_en = 1'b0;
    wait_done(2000, ok);
    check("ldp_done", bus.done, 1);
    repeat (3) @(negedge clk);
    start_run(8'd1, 8'd0);
    watch_play(1, 0, bad);
    check("ldp_replay_bad", bad, 0);
    wait_done(2000, ok);
    check("ldp_replay_done", bus.done, 1);
    repeat (3) @(negedge clk);

    // Reset mid-PLAY (second frame, sample 30), then replay from sample 0.
    start_run(8'd3, 8'd0);
    repeat (95) @(negedge clk);
    check("mid_di_re_30", bus.di_re, 16'h001e);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_di_en",   bus.di_en,   0);
    check("mid_busy",    bus.busy,    0);
    check("mid_done",    bus.done,    0);
    check("mid_timeout", bus.timeout, 0);
    check("mid_overrun", bus.overrun, 0);
    check("mid_out_cnt", bus.out_cnt, 0);
    check("mid_di_re",   bus.di_re,   0);
    check("mid_rd_re",   bus.rd_re,   0);
    repeat (12) @(negedge clk);
    check("mid_idle_ignores_do", bus.out_cnt, 0);
    start_run(8'd1, 8'd0);
    watch_play(1, 0, bad);
    check("mid_replay_bad", bad, 0);
    wait_done(2000, ok);
    check("mid_replay_done", bus.done, 1);
    check("mid_replay_out_cnt", bus.out_cnt, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
